// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed BCD seven-segment scanner with blanking,
// leading-zero suppression and frame-aligned shadow updates.
module seg7_scan_ctrl #(
    parameter int DIGITS = 4,
    parameter int DIV    = 50000,
    parameter int BLANK  = 500
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  lz,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);
    localparam int TW = $clog2(DIV);
    localparam int SW = DIGITS > 1 ? $clog2(DIGITS) : 1;

    logic [TW-1:0]       tick, tick_n;
    logic [SW-1:0]       slot, slot_n;
    logic [4*DIGITS-1:0] disp, disp_n, pend;
    logic                pend_v, boundary, xfer, dark;
    logic [3:0]          digit;
    logic [DIGITS-1:0]   hi_zero;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0: return 7'b0000001;
            4'd1: return 7'b1001111;
            4'd2: return 7'b0010010;
            4'd3: return 7'b0000110;
            4'd4: return 7'b1001100;
            4'd5: return 7'b0100100;
            4'd6: return 7'b0100000;
            4'd7: return 7'b0001111;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    // Outputs are registered from the next-state values so they always match
    // the tick/slot/disp held in the same cycle.
    always_comb begin
        boundary = enable && tick == TW'(DIV - 1) && slot == SW'(DIGITS - 1);
        xfer     = pend_v && (boundary || !enable);
        tick_n   = (!enable || tick == TW'(DIV - 1)) ? '0 : tick + 1'b1;
        slot_n   = !enable ? '0 :
                   tick != TW'(DIV - 1) ? slot :
                   slot == SW'(DIGITS - 1) ? '0 : slot + 1'b1;
        disp_n   = xfer ? pend : disp;
        hi_zero  = '0;
        hi_zero[DIGITS-1] = disp_n[4*DIGITS-1 -: 4] == 4'd0;
        for (int k = DIGITS - 2; k >= 0; k--)
            hi_zero[k] = hi_zero[k+1] && disp_n[4*k +: 4] == 4'd0;
        digit    = disp_n[{slot_n, 2'b00} +: 4];
        dark     = !enable || int'(tick_n) < BLANK ||
                   (lz && slot_n != '0 && hi_zero[slot_n]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick       <= '0;
            slot       <= '0;
            disp       <= '0;
            pend       <= '0;
            pend_v     <= 1'b0;
            seg        <= '1;
            an         <= '1;
            frame_done <= 1'b0;
        end else begin
            tick       <= tick_n;
            slot       <= slot_n;
            disp       <= disp_n;
            if (load) pend <= value;
            pend_v     <= load ? 1'b1 : xfer ? 1'b0 : pend_v;
            seg        <= dark ? '1 : decode(digit);
            an         <= dark ? '1 : ~(DIGITS'(1) << slot_n);
            frame_done <= tick_n == TW'(DIV - 1) && slot_n == SW'(DIGITS - 1);
        end
    end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed frame-by-frame scoreboard bench for seg7_scan_ctrl
// with DIGITS=4, DIV=8, BLANK=2.
module tb_seg7_scan_ctrl;
    logic        clk = 1'b0;
    logic        rst_n, enable, lz, load;
    logic [15:0] value;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    typedef struct {
        logic [6:0] seg;
        logic [3:0] an;
        logic       fd;
        string      name;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    logic [6:0] dec [0:15] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'h7f, 7'h7f,
                               7'h7f, 7'h7f, 7'h7f, 7'h7f};

    seg7_scan_ctrl #(.DIGITS(4), .DIV(8), .BLANK(2)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .lz(lz), .load(load),
        .value(value), .seg(seg), .an(an), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (seg !== e.seg || an !== e.an || frame_done !== e.fd) begin
                failures++;
                $display("FAIL %s: got seg=%b an=%b fd=%b, want seg=%b an=%b fd=%b",
                         e.name, seg, an, frame_done, e.seg, e.an, e.fd);
            end
        end
    end

    task automatic push(input logic [6:0] s, input logic [3:0] a, input logic f, input string n);
        exp_t e;
        e.seg = s; e.an = a; e.fd = f; e.name = n;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expect n cycles of a frame showing word w; loads are issued at cycles la1/la2.
    task automatic frame(input logic [15:0] w, input logic z, input int la1, input logic [15:0] lv1,
                         input int la2, input logic [15:0] lv2, input int n, input string nm);
        int s, t;
        logic [3:0] d;
        logic dk;
        lz = z;
        for (int c = 0; c < n; c++) begin
            s = c / 8;
            t = c % 8;
            d = w[4*s +: 4];
            dk = t < 2 || (z && s > 0 && (w >> (4*s)) == 16'h0);
            push(dk ? 7'h7f : dec[d], dk ? 4'hf : ~(4'b1 << s), c == 31, $sformatf("%s c%0d", nm, c));
            load = (c == la1) || (c == la2);
            value = (c == la2) ? lv2 : lv1;
            step();
        end
        load = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; lz = 1'b0; load = 1'b0; value = 16'h0;
        step();
        step();
        push(7'h7f, 4'hf, 1'b0, "reset");
        rst_n = 1'b1;
        value = 16'h1234; load = 1'b1;
        step();
        load = 1'b0;
        step();
        enable = 1'b1;
        frame(16'h1234, 0, -1, 0, -1, 0, 32, "basic");
        frame(16'h1234, 0, 10, 16'h5678, -1, 0, 32, "tear_old");
        frame(16'h5678, 0, 16, 16'h1111, 31, 16'h2222, 32, "tear_new");
        frame(16'h1111, 0, -1, 0, -1, 0, 32, "coll_first");
        frame(16'h2222, 0, 5, 16'h0070, -1, 0, 32, "coll_second");
        frame(16'h0070, 1, 5, 16'h0000, -1, 0, 32, "lz_0070");
        frame(16'h0000, 1, 5, 16'hFA09, -1, 0, 32, "lz_zero");
        frame(16'hFA09, 0, 20, 16'h1234, -1, 0, 21, "invalid");
        rst_n = 1'b0; enable = 1'b0;
        push(7'h7f, 4'hf, 1'b0, "async_reset");
        step();
        rst_n = 1'b1;
        step();
        enable = 1'b1;
        frame(16'h0000, 0, -1, 0, -1, 0, 28, "post_reset");
        push(7'b0000001, 4'b0111, 1'b0, "pre_disable");
        enable = 1'b0;
        step();
        push(7'h7f, 4'hf, 1'b0, "disabled");
        step();
        enable = 1'b1;
        frame(16'h0000, 0, -1, 0, -1, 0, 32, "rescan");
        repeat (2) @(posedge clk);
        if (q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain: %0d pending, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexed scan controller for a bank of common-anode seven-segment digits. It holds a DIGITS-wide BCD display word and steps one shared segment decoder across the digits, one slot at a time. Each slot opens with a programmable anti-ghosting blank interval. A shadow register defers display updates to frame boundaries, so a frame never shows a mix of old and new values. The block sits between the application's BCD counters and the board's segment and anode pins.

## Interface

- DIGITS, 4: number of digits scanned; legal range 1–8.
- DIV, 50000: clock cycles per digit slot; must be ≥ 2.
- BLANK, 500: cycles at the start of each slot with all anodes off; must be < DIV.

- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  1 = scanning; 0 = scan held and display dark.
- lz  in  1  1 = leading-zero suppression on.
- load  in  1  one-cycle strobe; captures `value` into the shadow register.
- value  in  4*DIGITS  BCD digits; digit k is value[4k+3:4k]; k = 0 is the rightmost (least significant) digit.
- seg  out  7  segment drive, active-low, bit order {a,b,c,d,e,f,g} MSB→LSB.
- an  out  DIGITS  anode select, active-low; an[k] drives digit k.
- frame_done  out  1  one-cycle pulse on the last cycle of each frame.

## Operation

- State:
  - tick counter, 0..DIV-1.
  - slot counter, 0..DIGITS-1.
  - disp: the live display word.
  - pend and pend_v: shadow word and its valid flag.
- Reset values: tick=0, slot=0, disp=0, pend=0, pend_v=0, seg=7'b1111111, an=all 1, frame_done=0.
- Every output is a register. seg, an and frame_done always reflect the tick/slot/disp values held in the same cycle.
- enable=1:
  - tick increments each cycle.
  - At tick=DIV-1, tick wraps to 0 and slot increments mod DIGITS.
  - The wrap from slot=DIGITS-1, tick=DIV-1 is the frame boundary.
- enable=0:
  - tick=0 and slot=0 are forced; an=all 1 and seg=all 1.
  - If pend_v is set, pend transfers to disp on every cycle.
- Slot output while enabled:
  - During the blank interval (tick < BLANK): an=all 1, seg=all 1.
  - Otherwise: an = ~(1<<slot), seg = decode(disp digit[slot]).
- decode, active-low:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - codes 10–15 = 1111111 (the anode is still driven).
- Leading-zero suppression (lz=1): slot k>0 is dark (an=all 1, seg=all 1) when digits k..DIGITS-1 of disp are all 0. Slot 0 is never suppressed.
- Shadow transfer:
  - load=1 writes pend←value and sets pend_v.
  - On the frame-boundary cycle, if pend_v was set before that cycle, disp←pend and pend_v clears.
  - load in the same cycle as the boundary: the old pend transfers, the new value is captured into pend, and pend_v stays 1. The new value displays on the following frame.
  - load while pend_v=1 overwrites pend; only the last load is ever displayed.
- frame_done = 1 exactly on the frame-boundary cycle. It is never asserted while enable=0.

## Timing

- Frame length = DIGITS*DIV cycles; digit on-time = DIV-BLANK cycles per frame.
- Disabled-to-enabled: with enable rising in cycle n, cycle n still shows tick=0 in the blank interval. The first lit cycle of slot 0 comes BLANK cycles later.
- Update latency: a load is visible from the start of the next frame. Worst case is DIGITS*DIV+1 cycles.
- enable falling mid-slot: outputs go dark in the following cycle, and the scan restarts at slot 0 on re-enable.
- rst_n low at any point, including mid-slot or mid-transfer: all outputs reach their reset values immediately and asynchronously. A pending load is lost.

## Test plan

Parameters: DIGITS=4, DIV=8, BLANK=2.

- **Basic scan.** Reset, load 16'h1234 with enable=0, then enable=1.
  - Frame cycles 0–1: an=1111.
  - Cycles 2–7: an=1110, seg=1001100.
  - Cycles 10–15: an=1101, seg=0000110.
  - Cycles 26–31: an=0111, seg=1001111.
  - frame_done high only at cycle 31.
- **Tearing guard.** disp=16'h1234; load 16'h5678 during slot 1.
  - Slots 2–3 still show 2 and 1.
  - The next frame shows 8, 7, 6, 5.
- **Boundary collision.** load 16'h1111 at slot 2, then load 16'h2222 on the frame-boundary cycle.
  - The next frame shows 1111.
  - The frame after that shows 2222.
- **Leading-zero suppression.** disp=16'h0070, lz=1: slot 0 seg=0000001, slot 1 seg=0001111, slots 2–3 an=1111 throughout. With disp=0, only slot 0 lights and shows 0.
- **Invalid codes.** disp=16'hFA09: slots 2–3 have their anode low and seg=1111111; slot 0 seg=0000100.
- **Reset and disable mid-scan.**
  - Drop rst_n at slot 2, tick 5: an=1111, seg=1111111 and frame_done=0 in the same cycle, and disp=0 after release.
  - Drop enable at slot 3: the display is dark the next cycle and rescans from slot 0.
